// File: rtl/transfer_controller_pkg.sv
// Shared package: FSM state encoding, counter width and phase-length helper.
package transfer_controller_pkg;

    localparam int unsigned CW = 8;

    typedef logic [CW-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Timer reload value for a phase of 'cycles' clocks, clamped to 1..255.
    // The timer expires when it reaches zero, so it is loaded with length-1.
    function automatic word_t phase_load(input int unsigned cycles);
        if (cycles <= 1) begin
            return '0;
        end else if (cycles >= 255) begin
            return word_t'(254);
        end else begin
            return word_t'(cycles - 1);
        end
    endfunction

endpackage

// File: rtl/transfer_controller_if.sv
// Handshake and status bundle between a frame requester and the controller.
interface transfer_controller_if;
    import transfer_controller_pkg::*;

    logic  Start;
    word_t NumWords;
    logic  Abort;
    logic  WordFlg;
    logic  EnCount;
    logic  CSn;
    logic  Busy;
    logic  WordDone;
    word_t WordIdx;
    logic  Done;
    logic  Aborted;

    modport master (
        output Start, NumWords, Abort, WordFlg,
        input  EnCount, CSn, Busy, WordDone, WordIdx, Done, Aborted
    );

    modport slave (
        input  Start, NumWords, Abort, WordFlg,
        output EnCount, CSn, Busy, WordDone, WordIdx, Done, Aborted
    );

endinterface

// File: rtl/transfer_controller_phase_timer.sv
// Down-counting phase timer: reloaded on a strobe, flags expiry at zero.
module PhaseTimer
    import transfer_controller_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  word_t load_val_i,
    input  logic  load_i,
    output logic  expired_o
);

    word_t cnt_q;

    // Reload on strobe, otherwise count down and park at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - word_t'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/transfer_controller.sv
// Chip-select / word framing controller: SETUP, XFER, HOLD, GAP sequencing.
module transfer_controller
    import transfer_controller_pkg::*;
#(
    parameter int unsigned SetupCycles = 2,
    parameter int unsigned HoldCycles  = 2,
    parameter int unsigned GapCycles   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    transfer_controller_if.slave bus
);

    localparam word_t SETUP_LD = phase_load(SetupCycles);
    localparam word_t HOLD_LD  = phase_load(HoldCycles);
    localparam word_t GAP_LD   = phase_load(GapCycles);

    state_t state_q, state_d;
    word_t  count_q, count_d;
    word_t  idx_q, idx_d;
    logic   aborted_q, aborted_d;
    logic   en_q, en_d;
    logic   csn_q, csn_d;
    logic   busy_q, busy_d;
    logic   wdone_q, wdone_d;
    logic   done_q, done_d;

    logic   tmr_load;
    word_t  tmr_val;
    logic   tmr_expired;

    PhaseTimer u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_val_i (tmr_val),
        .load_i     (tmr_load),
        .expired_o  (tmr_expired)
    );

    // Next-state logic; outputs are derived from the next state so that
    // they are registered and line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;
        wdone_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start && (bus.NumWords != '0)) begin
                    state_d   = ST_SETUP;
                    count_d   = bus.NumWords;
                    idx_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (bus.Abort) begin
                    state_d   = ST_HOLD;
                    aborted_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (bus.WordFlg) begin
                    idx_d   = idx_q + word_t'(1);
                    wdone_d = 1'b1;
                end
                if (bus.Abort) begin
                    state_d   = ST_HOLD;
                    aborted_d = 1'b1;
                end else if (bus.WordFlg && ((idx_q + word_t'(1)) == count_q)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_expired) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_d   = (state_d == ST_XFER);
        csn_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);

        tmr_load = (state_d != state_q);
        unique case (state_d)
            ST_SETUP: tmr_val = SETUP_LD;
            ST_HOLD:  tmr_val = HOLD_LD;
            ST_GAP:   tmr_val = GAP_LD;
            default:  tmr_val = '0;
        endcase
    end

    // State and registered outputs; reset wins over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            aborted_q <= 1'b0;
            en_q      <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            wdone_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            aborted_q <= aborted_d;
            en_q      <= en_d;
            csn_q     <= csn_d;
            busy_q    <= busy_d;
            wdone_q   <= wdone_d;
            done_q    <= done_d;
        end
    end

    assign bus.EnCount  = en_q;
    assign bus.CSn      = csn_q;
    assign bus.Busy     = busy_q;
    assign bus.WordDone = wdone_q;
    assign bus.WordIdx  = idx_q;
    assign bus.Done     = done_q;
    assign bus.Aborted  = aborted_q;

endmodule

// File: tb/tb_transfer_controller.sv
// Self-checking bench for transfer_controller (default phase parameters).
module tb_transfer_controller;
    import transfer_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    transfer_controller_if bus();

    transfer_controller #(
        .SetupCycles (2),
        .HoldCycles  (2),
        .GapCycles   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Frame scenario: stimulus plus hand-computed statistics relative to the
    // Start cycle (c=0). 0 in a "cycle" field means "never".
    typedef struct {
        int nwords;
        int flg_first;
        int flg_period;
        int abort_c;
        int exp_done_c;
        int exp_done_n;
        int exp_en_cnt;
        int exp_en_first;
        int exp_en_last;
        int exp_wd_cnt;
        int exp_wd_last;
        int exp_csn_cnt;
        int exp_busy_cnt;
        int exp_idx;
        int exp_abt;
    } vec_t;

    localparam int NVEC = 8;
    localparam int WIN  = 600;
    vec_t vecs[NVEC];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({bus.CSn, bus.EnCount, bus.Busy, bus.WordDone, bus.Done, bus.Aborted});
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int done_c = 0, done_n = 0, en_cnt = 0, en_first = 0, en_last = 0;
        int wd_cnt = 0, wd_last = 0, csn_cnt = 0, busy_cnt = 0;
        int idx_done = -1, abt_done = -1;
        string p;
        p = $sformatf("v%0d", id);
        for (int c = 0; c < WIN; c++) begin
            bus.Start    = (c == 0);
            bus.NumWords = word_t'(v.nwords);
            bus.Abort    = (v.abort_c != 0) && (c == v.abort_c);
            bus.WordFlg  = (c >= v.flg_first) && (((c - v.flg_first) % v.flg_period) == 0)
                           && (((c - v.flg_first) / v.flg_period) < v.nwords);
            @(negedge clk);
            if (c >= 1) begin
                if (bus.EnCount) begin
                    en_cnt++;
                    if (en_first == 0) en_first = c;
                    en_last = c;
                end
                if (bus.WordDone) begin
                    wd_cnt++;
                    wd_last = c;
                end
                if (!bus.CSn) csn_cnt++;
                if (bus.Busy) busy_cnt++;
                if (bus.Done) begin
                    done_n++;
                    if (done_c == 0) begin
                        done_c   = c;
                        idx_done = int'(bus.WordIdx);
                        abt_done = int'(bus.Aborted);
                    end
                end
            end
            tick();
        end
        bus.Start   = 1'b0;
        bus.Abort   = 1'b0;
        bus.WordFlg = 1'b0;
        check({p, " done_cycle"}, done_c, v.exp_done_c);
        check({p, " done_count"}, done_n, v.exp_done_n);
        check({p, " en_cycles"}, en_cnt, v.exp_en_cnt);
        check({p, " en_first"}, en_first, v.exp_en_first);
        check({p, " en_last"}, en_last, v.exp_en_last);
        check({p, " worddone_count"}, wd_cnt, v.exp_wd_cnt);
        check({p, " worddone_last"}, wd_last, v.exp_wd_last);
        check({p, " csn_low_cycles"}, csn_cnt, v.exp_csn_cnt);
        check({p, " busy_cycles"}, busy_cnt, v.exp_busy_cnt);
        check({p, " idx_held"}, int'(bus.WordIdx), v.exp_idx);
        check({p, " aborted_held"}, int'(bus.Aborted), v.exp_abt);
        if (v.exp_done_n != 0) begin
            check({p, " idx_at_done"}, idx_done, v.exp_idx);
            check({p, " aborted_at_done"}, abt_done, v.exp_abt);
        end
    endtask

    initial begin
        int done_n;
        int done_first;
        int done_second;
        int idx_second;

        //            n  ff per ab  done dn en  enF enL  wd wdL  csn busy idx abt
        vecs[0] = '{  3, 12, 8,  0,  35, 1, 26, 3,  28,  3, 29,  30, 34,  3, 0}; // nominal
        vecs[1] = '{  1, 12, 8,  0,  19, 1, 10, 3,  12,  1, 13,  14, 18,  1, 0}; // single word
        vecs[2] = '{  0, 12, 8,  0,   0, 0,  0, 0,   0,  0,  0,   0,  0,  1, 0}; // NumWords=0
        vecs[3] = '{  1, 12, 8, 13,  19, 1, 10, 3,  12,  1, 13,  14, 18,  1, 0}; // abort in HOLD
        vecs[4] = '{255,  4, 2,  0, 519, 1,510, 3, 512,255,513, 514,518,255, 0}; // 255 words
        vecs[5] = '{  4, 12, 8, 16,  23, 1, 14, 3,  16,  1, 13,  18, 22,  1, 1}; // abort word 2
        vecs[6] = '{  4, 12, 8,  1,   8, 1,  0, 0,   0,  0,  0,   3,  7,  0, 1}; // abort in SETUP
        vecs[7] = '{  4, 12, 8, 12,  19, 1, 10, 3,  12,  1, 13,  14, 18,  1, 1}; // abort + WordFlg

        bus.Start    = 1'b0;
        bus.NumWords = '0;
        bus.Abort    = 1'b0;
        bus.WordFlg  = 1'b0;

        // Reset state, with Start and Abort asserted to show reset wins.
        rst = 1'b1;
        bus.Start = 1'b1;
        bus.NumWords = 8'd3;
        bus.Abort = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset outputs", outs(), 6'b100000);
        check("reset idx", int'(bus.WordIdx), 0);
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while in HOLD after an abort: Aborted must clear.
        for (int c = 0; c < 8; c++) begin
            bus.Start    = (c == 0);
            bus.NumWords = 8'd3;
            bus.Abort    = (c == 4);
            rst          = (c == 6);
            @(negedge clk);
            if (c == 5) check("abort hold outputs", outs(), 6'b001001);
            if (c == 7) check("rst in hold outputs", outs(), 6'b100000);
            tick();
        end
        rst = 1'b0;
        bus.Abort = 1'b0;

        // Reset during XFER after one word; no Done may follow.
        done_n = 0;
        for (int c = 0; c < 50; c++) begin
            bus.Start   = (c == 0);
            bus.WordFlg = (c == 12);
            rst         = (c == 14);
            @(negedge clk);
            if (c == 13) check("xfer idx before rst", int'(bus.WordIdx), 1);
            if (c == 15) begin
                check("rst in xfer outputs", outs(), 6'b100000);
                check("rst in xfer idx", int'(bus.WordIdx), 0);
            end
            if (c >= 15 && bus.Done) done_n++;
            tick();
        end
        rst = 1'b0;
        bus.WordFlg = 1'b0;
        check("no done after rst", done_n, 0);
        run_vec(vecs[0], 8);

        // Start held high across Done, plus a stray Start while busy.
        done_n = 0;
        done_first = 0;
        done_second = 0;
        idx_second = -1;
        for (int c = 0; c < 60; c++) begin
            bus.Start    = (c <= 20) || (c == 25);
            bus.NumWords = (c == 25) ? 8'd5 : 8'd1;
            bus.WordFlg  = (c == 12) || (c == 32);
            @(negedge clk);
            if (bus.Done) begin
                done_n++;
                if (done_first == 0) begin
                    done_first = c;
                end else if (done_second == 0) begin
                    done_second = c;
                    idx_second = int'(bus.WordIdx);
                end
            end
            if (c == 18) check("held start gap busy", {bus.Busy, bus.CSn}, 2'b11);
            if (c == 20) check("held start restart", {bus.Busy, bus.CSn}, 2'b10);
            tick();
        end
        bus.Start   = 1'b0;
        bus.WordFlg = 1'b0;
        check("held start first done", done_first, 19);
        check("held start second done", done_second, 39);
        check("held start second idx", idx_second, 1);
        check("held start done count", done_n, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/transfer_controller.md
TRANSFER_CONTROLLER -- requirements
Module: TransferController

Interface
REQ-001 SHALL have parameter SetupCycles, default 2: clocks CSn is low before the first word; values of 0 behave as 1.
REQ-002 SHALL have parameter HoldCycles, default 2: clocks CSn stays low after the last word; values of 0 behave as 1.
REQ-003 SHALL have parameter GapCycles, default 4: minimum clocks CSn stays high before the next frame can start; values of 0 behave as 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Start, input, 1 bit: frame request, sampled in IDLE only.
REQ-007 SHALL have port NumWords, input, 8 bits: words per frame, latched on accepted Start.
REQ-008 SHALL have port Abort, input, 1 bit: terminates the frame early.
REQ-009 SHALL have port WordFlg, input, 1 bit: one-cycle end-of-word pulse from the word counter.
REQ-010 SHALL have port EnCount, output, 1 bit: enables the word counter and shift path.
REQ-011 SHALL have port CSn, output, 1 bit: active-low chip select.
REQ-012 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port WordDone, output, 1 bit: one-cycle pulse per completed word.
REQ-014 SHALL have port WordIdx, output, 8 bits: number of words completed in the current frame.
REQ-015 SHALL have port Done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-016 SHALL have port Aborted, output, 1 bit: valid with Done; 1 means the frame was terminated by Abort.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, XFER, HOLD and GAP, with all outputs registered.
REQ-018 IDLE: CSn=1, EnCount=0, Busy=0.
- Start=1 with NumWords!=0 at cycle t: latch NumWords, clear WordIdx, enter SETUP at t+1.
- Start with NumWords=0: ignored.
REQ-019 SETUP: CSn=0, EnCount=0; lasts exactly max(SetupCycles,1) cycles, then XFER.
REQ-020 XFER: CSn=0, EnCount=1 continuously across word boundaries; EnCount does not drop between words.
REQ-021 In XFER, each WordFlg SHALL, on the next cycle, increment WordIdx and pulse WordDone.
REQ-022 In XFER, the WordFlg that completes word NumWords SHALL also move the FSM to HOLD, so EnCount=0 on the following cycle.
REQ-023 HOLD: CSn=0, EnCount=0; lasts max(HoldCycles,1) cycles, then GAP.
REQ-024 GAP: CSn=1, Busy=1; lasts max(GapCycles,1) cycles, then IDLE.
REQ-025 Done SHALL pulse on the first IDLE cycle; Aborted SHALL be held until the next accepted Start.
REQ-026 Start outside IDLE SHALL be ignored, with no queuing.
REQ-027 Abort in SETUP or XFER SHALL go to HOLD on the next cycle and set Aborted.
REQ-028 Abort in HOLD, GAP or IDLE SHALL have no effect.
REQ-029 Abort and WordFlg in the same XFER cycle: the word SHALL be counted (WordIdx++, WordDone) and the FSM SHALL go to HOLD with Aborted=1.
REQ-030 WordFlg outside XFER SHALL be ignored.
REQ-031 WordIdx SHALL keep its final value after Done until the next accepted Start.
REQ-032 NumWords=255 SHALL complete 255 words with no wrap-around.
REQ-033 The phase timer SHALL be 8 bits, reloaded on each state entry, with parameters limited to 1..255.

Reset
REQ-034 With rst=1, next cycle values SHALL be: state IDLE, CSn=1, EnCount=0, Busy=0, WordDone=0, Done=0, Aborted=0, WordIdx=0, timer=0, latched count=0.
REQ-035 rst SHALL override Start and Abort and take effect mid-frame from any state, with no Done pulse.

Structure
REQ-036 The FSM state encoding and the 8-bit width constant SHALL live in the shared SPI package, also used by DataWordCounter's consumers.
REQ-037 The phase timer SHALL be one sub-module, PhaseTimer (load value, load strobe, expired flag); all other logic stays in TransferController.

Verification
REQ-038 Defaults; NumWords=3; Start at t; WordFlg pulses at t+12, t+20, t+28 -> CSn=0 from t+1; EnCount=1 over t+3..t+28; WordDone at t+13, t+21, t+29; CSn=1 at t+31; Done at t+35 with Aborted=0 and WordIdx=3.
REQ-039 Start with NumWords=0 -> Busy, CSn and Done stay at idle values.
REQ-040 Abort during word 2 of 4 -> EnCount=0 next cycle; HOLD then GAP; Done with Aborted=1 and WordIdx=1.
REQ-041 Abort coincident with the first WordFlg -> WordIdx=1, Aborted=1, no further EnCount.
REQ-042 rst during XFER -> all outputs at reset values the next cycle; no Done; a new Start works normally.
REQ-043 Start held high across Done -> second frame starts the cycle after Done, preceded by a full GAP; Start pulses during Busy are ignored.
